hex_key_entry: RTL and testbench

Sits directly downstream of the debounce/pulse-sync front end and consumes its one-cycle pulses: 16 hex keys, backspace, previous, next and execute. It builds a hex value digit by digit, navigates an address pointer, and commits entries to a 1-cycle-latency memory/register file. When not editing, it reads back and displays the contents at the current address.

---
 rtl/hex_key_entry_pkg.sv | 23 ++
 rtl/hex_key_entry_if.sv | 33 +++
 rtl/hex_key_entry_key_enc16.sv | 16 +
 rtl/hex_key_entry.sv | 144 ++++++++++++++
 tb/tb_hex_key_entry.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/hex_key_entry_pkg.sv
// Shared types and constants for the hex key entry block.
package hex_key_entry_pkg;

  localparam int unsigned DEF_DW = 32;
  localparam int unsigned DEF_AW = 8;
  localparam int unsigned ND     = DEF_DW / 4;
  localparam int unsigned CW     = $clog2(ND) + 1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_SHOW,
    ST_EDIT,
    ST_WRITE,
    ST_LOAD,
    ST_CAP
  } state_t;

  // Digit counter width for a given data width (counts 0..DW/4 inclusive).
  function automatic int unsigned cnt_width(input int unsigned dw);
    return $clog2(dw / 4) + 1;
  endfunction

endpackage

// File: rtl/hex_key_entry_if.sv
// Key pulse inputs, memory port and display outputs of the hex key entry block.
interface hex_key_entry_if #(
  parameter int unsigned DW = hex_key_entry_pkg::DEF_DW,
  parameter int unsigned AW = hex_key_entry_pkg::DEF_AW,
  parameter int unsigned CW = hex_key_entry_pkg::cnt_width(DW)
);

  logic [15:0]   d_ps;
  logic          bs_ps;
  logic          pre_ps;
  logic          nxt_ps;
  logic          exe_ps;
  logic [DW-1:0] rdata;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [CW-1:0] cnt;
  logic          editing;
  logic          busy;
  logic          we;
  logic [DW-1:0] wdata;
  logic          re;

  modport master (
    output d_ps, bs_ps, pre_ps, nxt_ps, exe_ps, rdata,
    input  addr, data, cnt, editing, busy, we, wdata, re
  );

  modport slave (
    input  d_ps, bs_ps, pre_ps, nxt_ps, exe_ps, rdata,
    output addr, data, cnt, editing, busy, we, wdata, re
  );

endinterface

// File: rtl/hex_key_entry_key_enc16.sv
// One-hot to hex digit encoder; valid only when exactly one key bit is set.
module key_enc16 (
  input  logic [15:0] onehot,
  output logic [3:0]  digit,
  output logic        valid
);

  always_comb begin
    digit = '0;
    valid = (onehot != '0) && ((onehot & (onehot - 16'(1))) == '0);
    for (int i = 0; i < 16; i++) begin
      if (onehot[i]) digit = 4'(i);
    end
  end

endmodule

// File: rtl/hex_key_entry.sv
// Digit-by-digit hex entry with address navigation, commit-to-memory and read-back display.
module hex_key_entry
  import hex_key_entry_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  hex_key_entry_if.slave bus
);

  localparam int unsigned NDIG = DW / 4;
  localparam int unsigned CNTW = cnt_width(DW);

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic [CNTW-1:0] cnt_q;
  logic [DW-1:0]   wdata_q;

  logic [3:0] key_digit;
  logic       key_valid;
  logic       ev_exe;
  logic       ev_bs;
  logic       ev_pre;
  logic       ev_nxt;
  logic       ev_dig;
  logic       nav_ok;
  logic       we;
  logic       re;
  logic       editing;
  logic       busy;

  key_enc16 u_enc (
    .onehot (bus.d_ps),
    .digit  (key_digit),
    .valid  (key_valid)
  );

  // Single winning event per cycle: exe > bs > pre/nxt > digit; pre+nxt cancels all below.
  always_comb begin
    ev_exe = bus.exe_ps;
    ev_bs  = !bus.exe_ps && bus.bs_ps;
    nav_ok = !bus.exe_ps && !bus.bs_ps;
    ev_pre = nav_ok && bus.pre_ps && !bus.nxt_ps;
    ev_nxt = nav_ok && bus.nxt_ps && !bus.pre_ps;
    ev_dig = nav_ok && !bus.pre_ps && !bus.nxt_ps && key_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_CAP;
      ST_CAP:   state_d = ST_SHOW;
      ST_WRITE: state_d = ST_LOAD;
      ST_SHOW: begin
        if (ev_pre || ev_nxt) state_d = ST_LOAD;
        else if (ev_dig)      state_d = ST_EDIT;
      end
      ST_EDIT: begin
        if (ev_exe)                state_d = ST_WRITE;
        else if (ev_pre || ev_nxt) state_d = ST_LOAD;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    we      = 1'b0;
    re      = 1'b0;
    editing = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_INIT:  busy = 1'b1;
      ST_WRITE: begin we = 1'b1; busy = 1'b1; end
      ST_LOAD:  begin re = 1'b1; busy = 1'b1; end
      ST_CAP:   busy = 1'b1;
      ST_EDIT:  editing = 1'b1;
      default:  ;
    endcase
  end

  // Address pointer, display/edit buffer, digit count and committed write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        ST_CAP: begin
          data_q <= bus.rdata;
          cnt_q  <= '0;
        end
        ST_WRITE: addr_q <= addr_q + AW'(1);
        ST_SHOW: begin
          if (ev_pre)      addr_q <= addr_q - AW'(1);
          else if (ev_nxt) addr_q <= addr_q + AW'(1);
          else if (ev_dig) begin
            data_q <= DW'(key_digit);
            cnt_q  <= CNTW'(1);
          end
        end
        ST_EDIT: begin
          if (ev_exe) begin
            wdata_q <= data_q;
          end else if (ev_bs) begin
            if (cnt_q != '0) begin
              data_q <= data_q >> 4;
              cnt_q  <= cnt_q - CNTW'(1);
            end
          end else if (ev_pre) begin
            addr_q <= addr_q - AW'(1);
          end else if (ev_nxt) begin
            addr_q <= addr_q + AW'(1);
          end else if (ev_dig && (cnt_q < CNTW'(NDIG))) begin
            data_q <= {data_q[DW-5:0], key_digit};
            cnt_q  <= cnt_q + CNTW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.addr    = addr_q;
  assign bus.data    = data_q;
  assign bus.cnt     = cnt_q;
  assign bus.wdata   = wdata_q;
  assign bus.we      = we;
  assign bus.re      = re;
  assign bus.editing = editing;
  assign bus.busy    = busy;

endmodule

// File: tb/tb_hex_key_entry.sv
// Directed bench for hex_key_entry with a 1-cycle-latency memory model.
module tb_hex_key_entry;
  import hex_key_entry_pkg::*;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  logic [31:0] mem [256];

  hex_key_entry_if #(.DW(32), .AW(8), .CW(4)) bus ();

  hex_key_entry #(.DW(32), .AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.we) mem[bus.addr] <= bus.wdata;
    if (bus.re) bus.rdata <= mem[bus.addr];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    bus.d_ps = 16'(1) << d;
    tick();
    bus.d_ps = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++; if (bus.addr !== 8'h00) $display("FAIL rst_addr: got %h exp 00", bus.addr); else pass_cnt++;
    total_cnt++; if (bus.data !== 32'h0) $display("FAIL rst_data: got %h exp 0", bus.data); else pass_cnt++;
    total_cnt++; if (bus.cnt !== 4'd0) $display("FAIL rst_cnt: got %0d exp 0", bus.cnt); else pass_cnt++;
    total_cnt++; if ({bus.busy, bus.we, bus.re, bus.editing} !== 4'b1000) $display("FAIL rst_flags: got %b exp 1000", {bus.busy, bus.we, bus.re, bus.editing}); else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++; if (bus.re !== 1'b1) $display("FAIL pwr_re: got %b exp 1", bus.re); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (bus.data !== 32'hDEADBEEF) $display("FAIL pwr_data: got %h exp DEADBEEF", bus.data); else pass_cnt++;
    total_cnt++; if ({bus.busy, bus.editing, bus.cnt} !== 6'b000000) $display("FAIL pwr_show: got busy/edit/cnt %b exp 000000", {bus.busy, bus.editing, bus.cnt}); else pass_cnt++;
  endtask

  task automatic test_edit_write();
    key(4'h1);
    total_cnt++; if ({bus.editing, bus.data} !== {1'b1, 32'h1}) $display("FAIL first_digit: got %b/%h exp 1/00000001", bus.editing, bus.data); else pass_cnt++;
    key(4'h2);
    key(4'hA);
    total_cnt++; if ({bus.cnt, bus.data} !== {4'd3, 32'h0000012A}) $display("FAIL three_digits: got %0d/%h exp 3/0000012A", bus.cnt, bus.data); else pass_cnt++;
    bus.bs_ps = 1'b1; tick(); bus.bs_ps = 1'b0;
    total_cnt++; if ({bus.cnt, bus.data} !== {4'd2, 32'h00000012}) $display("FAIL backspace: got %0d/%h exp 2/00000012", bus.cnt, bus.data); else pass_cnt++;
    bus.exe_ps = 1'b1; tick(); bus.exe_ps = 1'b0;
    total_cnt++; if ({bus.we, bus.wdata, bus.addr} !== {1'b1, 32'h12, 8'h00}) $display("FAIL write_cycle: got we=%b wdata=%h addr=%h exp 1/00000012/00", bus.we, bus.wdata, bus.addr); else pass_cnt++;
    tick();
    total_cnt++; if ({bus.we, bus.re, bus.addr} !== {1'b0, 1'b1, 8'h01}) $display("FAIL post_write_load: got we=%b re=%b addr=%h exp 0/1/01", bus.we, bus.re, bus.addr); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if ({bus.data, bus.cnt} !== {32'h11111111, 4'd0}) $display("FAIL post_write_show: got %h/%0d exp 11111111/0", bus.data, bus.cnt); else pass_cnt++;
  endtask

  task automatic test_digit_limits();
    for (int k = 1; k <= 8; k++) key(4'(k));
    total_cnt++; if ({bus.cnt, bus.data} !== {4'd8, 32'h12345678}) $display("FAIL eight_digits: got %0d/%h exp 8/12345678", bus.cnt, bus.data); else pass_cnt++;
    key(4'h9);
    total_cnt++; if ({bus.cnt, bus.data} !== {4'd8, 32'h12345678}) $display("FAIL ninth_digit: got %0d/%h exp 8/12345678", bus.cnt, bus.data); else pass_cnt++;
    bus.d_ps = 16'h0003; tick(); bus.d_ps = '0;
    total_cnt++; if ({bus.editing, bus.cnt, bus.data} !== {1'b1, 4'd8, 32'h12345678}) $display("FAIL two_keys: got %b/%0d/%h exp 1/8/12345678", bus.editing, bus.cnt, bus.data); else pass_cnt++;
    bus.pre_ps = 1'b1; tick(); bus.pre_ps = 1'b0;
    total_cnt++; if ({bus.addr, bus.re, bus.editing} !== {8'h00, 1'b1, 1'b0}) $display("FAIL edit_pre: got addr=%h re=%b edit=%b exp 00/1/0", bus.addr, bus.re, bus.editing); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (bus.data !== 32'h00000012) $display("FAIL readback_mem0: got %h exp 00000012", bus.data); else pass_cnt++;
  endtask

  task automatic test_bs_edges();
    bus.bs_ps = 1'b1; tick(); bus.bs_ps = 1'b0;
    total_cnt++; if ({bus.editing, bus.data} !== {1'b0, 32'h12}) $display("FAIL bs_in_show: got %b/%h exp 0/00000012", bus.editing, bus.data); else pass_cnt++;
    key(4'h4);
    bus.bs_ps = 1'b1; tick(); tick(); bus.bs_ps = 1'b0;
    total_cnt++; if ({bus.editing, bus.cnt, bus.data} !== {1'b1, 4'd0, 32'h0}) $display("FAIL bs_to_empty: got %b/%0d/%h exp 1/0/00000000", bus.editing, bus.cnt, bus.data); else pass_cnt++;
    bus.exe_ps = 1'b1; tick(); bus.exe_ps = 1'b0;
    total_cnt++; if ({bus.we, bus.wdata} !== {1'b1, 32'h0}) $display("FAIL empty_commit: got we=%b wdata=%h exp 1/00000000", bus.we, bus.wdata); else pass_cnt++;
    tick();
    tick();
    tick();
    total_cnt++; if ({bus.addr, bus.data} !== {8'h01, 32'h11111111}) $display("FAIL empty_commit_next: got %h/%h exp 01/11111111", bus.addr, bus.data); else pass_cnt++;
  endtask

  task automatic test_navigation();
    bus.pre_ps = 1'b1; tick(); bus.pre_ps = 1'b0;
    tick();
    tick();
    total_cnt++; if ({bus.addr, bus.data} !== {8'h00, 32'h0}) $display("FAIL nav_to_0: got %h/%h exp 00/00000000", bus.addr, bus.data); else pass_cnt++;
    bus.pre_ps = 1'b1; tick(); bus.pre_ps = 1'b0;
    total_cnt++; if ({bus.addr, bus.re} !== {8'hFF, 1'b1}) $display("FAIL pre_wrap: got addr=%h re=%b exp FF/1", bus.addr, bus.re); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (bus.data !== 32'hF00DF00D) $display("FAIL mem255: got %h exp F00DF00D", bus.data); else pass_cnt++;
    bus.nxt_ps = 1'b1; tick(); bus.nxt_ps = 1'b0;
    total_cnt++; if ({bus.addr, bus.re} !== {8'h00, 1'b1}) $display("FAIL nxt_wrap: got addr=%h re=%b exp 00/1", bus.addr, bus.re); else pass_cnt++;
    tick();
    tick();
    bus.pre_ps = 1'b1; bus.nxt_ps = 1'b1; bus.d_ps = 16'h0020;
    tick();
    bus.pre_ps = 1'b0; bus.nxt_ps = 1'b0; bus.d_ps = '0;
    total_cnt++; if ({bus.addr, bus.re, bus.editing, bus.data} !== {8'h00, 1'b0, 1'b0, 32'h0}) $display("FAIL pre_nxt_both: got addr=%h re=%b edit=%b data=%h exp 00/0/0/00000000", bus.addr, bus.re, bus.editing, bus.data); else pass_cnt++;
  endtask

  task automatic test_priority_busy();
    key(4'h7);
    key(4'h3);
    bus.exe_ps = 1'b1; bus.bs_ps = 1'b1; bus.d_ps = 16'h0010;
    tick();
    bus.exe_ps = 1'b0; bus.bs_ps = 1'b0; bus.d_ps = '0;
    total_cnt++; if ({bus.we, bus.wdata, bus.data, bus.cnt} !== {1'b1, 32'h73, 32'h73, 4'd2}) $display("FAIL exe_wins: got we=%b wdata=%h data=%h cnt=%0d exp 1/00000073/00000073/2", bus.we, bus.wdata, bus.data, bus.cnt); else pass_cnt++;
    bus.nxt_ps = 1'b1; bus.d_ps = 16'h0020;
    tick();
    bus.nxt_ps = 1'b0; bus.d_ps = '0;
    total_cnt++; if ({bus.addr, bus.re, bus.we} !== {8'h01, 1'b1, 1'b0}) $display("FAIL busy_write: got addr=%h re=%b we=%b exp 01/1/0", bus.addr, bus.re, bus.we); else pass_cnt++;
    bus.bs_ps = 1'b1; tick(); bus.bs_ps = 1'b0;
    total_cnt++; if ({bus.busy, bus.re, bus.addr} !== {1'b1, 1'b0, 8'h01}) $display("FAIL busy_load: got busy=%b re=%b addr=%h exp 1/0/01", bus.busy, bus.re, bus.addr); else pass_cnt++;
    bus.pre_ps = 1'b1; bus.d_ps = 16'h0002;
    tick();
    bus.pre_ps = 1'b0; bus.d_ps = '0;
    total_cnt++; if ({bus.busy, bus.editing, bus.addr, bus.data} !== {1'b0, 1'b0, 8'h01, 32'h11111111}) $display("FAIL busy_cap: got busy=%b edit=%b addr=%h data=%h exp 0/0/01/11111111", bus.busy, bus.editing, bus.addr, bus.data); else pass_cnt++;
    bus.pre_ps = 1'b1; tick(); bus.pre_ps = 1'b0;
    tick();
    tick();
    total_cnt++; if ({bus.addr, bus.data} !== {8'h00, 32'h73}) $display("FAIL commit_readback: got %h/%h exp 00/00000073", bus.addr, bus.data); else pass_cnt++;
  endtask

  task automatic test_reset_in_write();
    key(4'h9);
    bus.exe_ps = 1'b1; tick(); bus.exe_ps = 1'b0;
    total_cnt++; if (bus.we !== 1'b1) $display("FAIL rw_we: got %b exp 1", bus.we); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if ({bus.we, bus.busy, bus.addr, bus.data, bus.wdata, bus.cnt} !== {1'b0, 1'b1, 8'h00, 32'h0, 32'h0, 4'd0}) $display("FAIL rw_reset: got we=%b busy=%b addr=%h data=%h wdata=%h cnt=%0d exp 0/1/00/0/0/0", bus.we, bus.busy, bus.addr, bus.data, bus.wdata, bus.cnt); else pass_cnt++;
    tick();
    total_cnt++; if ({bus.we, bus.re, bus.addr} !== {1'b0, 1'b1, 8'h00}) $display("FAIL rw_restart: got we=%b re=%b addr=%h exp 0/1/00", bus.we, bus.re, bus.addr); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if ({bus.busy, bus.addr, bus.data} !== {1'b0, 8'h00, 32'h9}) $display("FAIL rw_show: got busy=%b addr=%h data=%h exp 0/00/00000009", bus.busy, bus.addr, bus.data); else pass_cnt++;
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    rst        = 1'b1;
    bus.d_ps   = '0;
    bus.bs_ps  = 1'b0;
    bus.pre_ps = 1'b0;
    bus.nxt_ps = 1'b0;
    bus.exe_ps = 1'b0;
    bus.rdata  = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'hDEADBEEF;
    mem[1]   = 32'h11111111;
    mem[255] = 32'hF00DF00D;

    test_reset();
    test_edit_write();
    test_digit_limits();
    test_bs_edges();
    test_navigation();
    test_priority_busy();
    test_reset_in_write();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
